aud_i2s_adc_tx: RTL and testbench

AUD_I2S_ADC_TX -- requirements
Module: aud_i2s_adc_tx

---
 rtl/aud_i2s_adc_tx_if.sv | 19 +
 rtl/aud_i2s_adc_tx.sv | 151 +++++++++++++++
 tb/tb_aud_i2s_adc_tx.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/aud_i2s_adc_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : aud_i2s_adc_tx_if
// Description : Sample-push handshake bundle for aud_i2s_adc_tx: one stereo
//               frame (left/right two's-complement words) per accepted beat.
// Revision    : 1.0 - initial release
// ============================================================================
interface aud_i2s_adc_tx_if;
  logic        i_valid;
  logic        o_ready;
  logic [15:0] i_left;
  logic [15:0] i_right;

  // Producer side: offers frames, observes back-pressure
  modport master (output i_valid, output i_left, output i_right, input o_ready);
  // Transmitter side: accepts frames, drives back-pressure
  modport slave  (input i_valid, input i_left, input i_right, output o_ready);
endinterface
`default_nettype wire

// File: rtl/aud_i2s_adc_tx.sv
`default_nettype none
// ============================================================================
// Module      : aud_i2s_adc_tx
// Description : I2S ADC-side serial transmitter. Buffers stereo frames in a
//               small FIFO and shifts them out MSB first, one BCLK after each
//               LRCK transition driven by the codec master.
// Revision    : 1.0 - initial release
// ============================================================================
module aud_i2s_adc_tx #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 20
) (
  input  wire logic             i_AUD_BCLK,
  input  wire logic             i_rst_n,
  input  wire logic             i_lrc,
  input  wire logic             i_en,
  aud_i2s_adc_tx_if.slave       push,
  output      logic             o_adcdat,
  output      logic             o_underrun,
  output      logic             o_busy,
  output      logic [CNT_W-1:0] o_frame_cnt
);

  localparam int             AW        = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]    FULL_CNT  = (AW+1)'(FIFO_DEPTH);
  localparam logic [4:0]     BITS_DONE = 5'd16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } state_t;

  state_t           state;
  logic             lrc_q;
  logic [31:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      fifo_count;
  logic [15:0]      shreg;
  logic [15:0]      hold_right;
  logic [4:0]       bit_cnt;

  logic             left_start;
  logic             right_start;
  logic             do_push;
  logic             do_pop;
  logic             tx_bit;

  // LRCK high->low opens a left channel, low->high opens a right channel
  assign left_start  = lrc_q & ~i_lrc;
  assign right_start = ~lrc_q & i_lrc;

  // Ready depends only on the registered count, so a frame pushed this cycle
  // can never be popped in the same cycle
  assign push.o_ready = (fifo_count != FULL_CNT);
  assign do_push      = push.i_valid & push.o_ready;
  assign do_pop       = left_start & i_en & (state != IDLE) & (fifo_count != '0);

  assign o_busy = (state != IDLE);

  // Serial bit is the shift-register MSB while a word is still being sent
  assign tx_bit = ((state == LEFT) || (state == RIGHT)) && (bit_cnt != BITS_DONE)
                  ? shreg[15] : 1'b0;

  // Capture LRCK to detect channel boundaries
  always_ff @(posedge i_AUD_BCLK or negedge i_rst_n) begin
    if (!i_rst_n) lrc_q <= 1'b1;
    else          lrc_q <= i_lrc;
  end

  // Frame storage; contents need no reset because pointers define validity
  always_ff @(posedge i_AUD_BCLK) begin
    if (do_push) mem[wr_ptr] <= {push.i_left, push.i_right};
  end

  // FIFO pointers and occupancy; push+pop together leaves the count unchanged
  always_ff @(posedge i_AUD_BCLK or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      fifo_count <= fifo_count + 1'b1;
      else if (do_pop && !do_push) fifo_count <= fifo_count - 1'b1;
    end
  end

  // Channel sequencer: loads words at channel starts and shifts them out
  always_ff @(posedge i_AUD_BCLK or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      shreg       <= '0;
      hold_right  <= '0;
      bit_cnt     <= BITS_DONE;
      o_underrun  <= 1'b0;
      o_frame_cnt <= '0;
    end else begin
      o_underrun <= 1'b0;
      case (state)
        IDLE: begin
          if (i_en) begin
            state       <= ARMED;
            o_frame_cnt <= '0;
          end
        end
        default: begin
          if (left_start) begin
            // Enable is only sampled here so a started frame always finishes
            if (!i_en) begin
              state   <= IDLE;
              shreg   <= '0;
              bit_cnt <= BITS_DONE;
            end else begin
              state   <= LEFT;
              bit_cnt <= '0;
              if (do_pop) begin
                shreg       <= mem[rd_ptr][31:16];
                hold_right  <= mem[rd_ptr][15:0];
                o_frame_cnt <= o_frame_cnt + CNT_W'(1);
              end else begin
                shreg      <= '0;
                hold_right <= '0;
                o_underrun <= 1'b1;
              end
            end
          end else if (right_start && (state == LEFT)) begin
            // A short left half simply abandons the remaining left bits
            state   <= RIGHT;
            shreg   <= hold_right;
            bit_cnt <= '0;
          end else if (bit_cnt != BITS_DONE) begin
            shreg   <= {shreg[14:0], 1'b0};
            bit_cnt <= bit_cnt + 5'd1;
          end
        end
      endcase
    end
  end

  // Launch data on the falling edge so the receiver sees it stable on rising
  always_ff @(negedge i_AUD_BCLK or negedge i_rst_n) begin
    if (!i_rst_n) o_adcdat <= 1'b0;
    else          o_adcdat <= tx_bit;
  end

endmodule
`default_nettype wire

// File: tb/tb_aud_i2s_adc_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_aud_i2s_adc_tx
// Description : Directed bench for aud_i2s_adc_tx: table of stereo frames plus
//               hand-written sequences for FIFO full, enable drop, short LRCK
//               halves, same-cycle push/start and mid-word reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aud_i2s_adc_tx;

  logic       clk;
  logic       rst_n;
  logic       lrc;
  logic       en;
  logic       adcdat;
  logic       underrun;
  logic       busy;
  logic [2:0] frame_cnt;

  int n_pass;
  int n_total;

  aud_i2s_adc_tx_if bus ();

  // Narrow frame counter so the wrap from 7 to 0 is exercised
  aud_i2s_adc_tx #(
    .FIFO_DEPTH (4),
    .CNT_W      (3)
  ) dut (
    .i_AUD_BCLK  (clk),
    .i_rst_n     (rst_n),
    .i_lrc       (lrc),
    .i_en        (en),
    .push        (bus.slave),
    .o_adcdat    (adcdat),
    .o_underrun  (underrun),
    .o_busy      (busy),
    .o_frame_cnt (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        push;
    logic [15:0] pl;
    logic [15:0] pr;
    logic [15:0] el;
    logic [15:0] er;
    int          eurun;
    logic [2:0]  ecnt;
  } vec_t;

  vec_t tbl [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else             n_pass++;
  endtask

  task automatic push_frame(input logic [15:0] l, input logic [15:0] r);
    @(negedge clk);
    bus.i_valid = 1'b1;
    bus.i_left  = l;
    bus.i_right = r;
    @(negedge clk);
    bus.i_valid = 1'b0;
  endtask

  // One LRCK period: capture bits sampled on rises 2..17 of each half
  task automatic run_frame(input int half, input int drop_at, input logic push_now,
                           input logic [15:0] pl, input logic [15:0] pr,
                           output logic [15:0] lw, output logic [15:0] rw,
                           output int urun, output logic rdy1);
    lw = '0; rw = '0; urun = 0; rdy1 = 1'b0;
    @(negedge clk);
    lrc = 1'b0;
    if (push_now) begin
      bus.i_valid = 1'b1;
      bus.i_left  = pl;
      bus.i_right = pr;
    end
    for (int i = 1; i <= half; i++) begin
      @(posedge clk); #1;
      if (i == 1) begin
        rdy1        = bus.o_ready;
        bus.i_valid = 1'b0;
      end
      if (i >= 2 && i <= 17) lw[17-i] = adcdat;
      if (underrun) urun++;
      if (i == drop_at) en = 1'b0;
    end
    @(negedge clk);
    lrc = 1'b1;
    for (int i = 1; i <= half; i++) begin
      @(posedge clk); #1;
      if (i >= 2 && i <= 17) rw[17-i] = adcdat;
      if (underrun) urun++;
    end
  endtask

  task automatic frame_chk(input string tag, input int half, input int drop_at,
                           input logic push_now, input logic [15:0] pl, input logic [15:0] pr,
                           input logic [15:0] el, input logic [15:0] er,
                           input int eurun, input logic [2:0] ecnt);
    logic [15:0] lw, rw;
    int          urun;
    logic        rdy1;
    run_frame(half, drop_at, push_now, pl, pr, lw, rw, urun, rdy1);
    chk({tag, ".left"},   {16'h0, lw}, {16'h0, el});
    chk({tag, ".right"},  {16'h0, rw}, {16'h0, er});
    chk({tag, ".urun"},   urun, eurun);
    chk({tag, ".fcnt"},   {29'h0, frame_cnt}, {29'h0, ecnt});
  endtask

  // Watchdog so the run always ends
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] lw, rw;
    int          urun;
    logic        rdy1;

    n_pass  = 0;
    n_total = 0;

    tbl[0] = '{1'b1, 16'h8001, 16'h7FFE, 16'h8001, 16'h7FFE, 0, 3'd1};
    tbl[1] = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1, 3'd1};
    tbl[2] = '{1'b1, 16'hA5A5, 16'h5A5A, 16'hA5A5, 16'h5A5A, 0, 3'd2};
    tbl[3] = '{1'b1, 16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF, 0, 3'd3};
    tbl[4] = '{1'b1, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0001, 0, 3'd4};

    rst_n       = 1'b0;
    lrc         = 1'b1;
    en          = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_left  = '0;
    bus.i_right = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst.ready",    bus.o_ready, 1);
    chk("rst.adcdat",   adcdat, 0);
    chk("rst.busy",     busy, 0);
    chk("rst.underrun", underrun, 0);
    chk("rst.fcnt",     frame_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("arm.busy", busy, 1);

    // Table of full-length frames
    for (int v = 0; v < 5; v++) begin
      if (tbl[v].push) push_frame(tbl[v].pl, tbl[v].pr);
      frame_chk($sformatf("vec%0d", v), 32, 0, 1'b0, 16'h0, 16'h0,
                tbl[v].el, tbl[v].er, tbl[v].eurun, tbl[v].ecnt);
    end

    // Push on the same edge as a left start is not visible to that start
    frame_chk("bypass", 32, 0, 1'b1, 16'h1234, 16'h5678, 16'h0, 16'h0, 1, 3'd4);
    frame_chk("bypass2", 32, 0, 1'b0, 16'h0, 16'h0, 16'h1234, 16'h5678, 0, 3'd5);

    // Fill the FIFO with no LRCK edges; the fifth offer must be ignored
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 4) chk("full.ready", bus.o_ready, 0);
      bus.i_valid = 1'b1;
      bus.i_left  = 16'h1000 + 16'(k);
      bus.i_right = 16'h2000 + 16'(k);
    end
    @(negedge clk);
    bus.i_valid = 1'b0;
    chk("full.ready5", bus.o_ready, 0);
    run_frame(32, 0, 1'b0, 16'h0, 16'h0, lw, rw, urun, rdy1);
    chk("full.rdy_after_pop", rdy1, 1);
    chk("full.f0.left", lw, 16'h1000);
    chk("full.f0.right", rw, 16'h2000);
    chk("full.f0.fcnt", frame_cnt, 3'd6);
    frame_chk("full.f1", 32, 0, 1'b0, 16'h0, 16'h0, 16'h1001, 16'h2001, 0, 3'd7);
    frame_chk("full.f2", 32, 0, 1'b0, 16'h0, 16'h0, 16'h1002, 16'h2002, 0, 3'd0);
    frame_chk("full.f3", 32, 0, 1'b0, 16'h0, 16'h0, 16'h1003, 16'h2003, 0, 3'd1);
    frame_chk("full.f4", 32, 0, 1'b0, 16'h0, 16'h0, 16'h0000, 16'h0000, 1, 3'd1);

    // Enable dropped mid-left: frame completes, then IDLE with FIFO kept
    push_frame(16'hC3C3, 16'h3C3C);
    push_frame(16'h0F0F, 16'hF0F0);
    frame_chk("endrop", 32, 8, 1'b0, 16'h0, 16'h0, 16'hC3C3, 16'h3C3C, 0, 3'd2);
    frame_chk("idle", 32, 0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 0, 3'd2);
    chk("idle.busy", busy, 0);
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    chk("rearm.busy", busy, 1);
    chk("rearm.fcnt", frame_cnt, 3'd0);
    frame_chk("rearm", 32, 0, 1'b0, 16'h0, 16'h0, 16'h0F0F, 16'hF0F0, 0, 3'd1);

    // Short LRCK halves: only the top nine bits make it out
    push_frame(16'hABCD, 16'h1357);
    frame_chk("short0", 10, 0, 1'b0, 16'h0, 16'h0, 16'hAB80, 16'h1300, 0, 3'd2);
    push_frame(16'h8421, 16'h7BDE);
    frame_chk("short1", 10, 0, 1'b0, 16'h0, 16'h0, 16'h8400, 16'h7B80, 0, 3'd3);

    // Reset in the middle of a left word with two frames queued
    push_frame(16'hFFFF, 16'hFFFF);
    push_frame(16'hFFFF, 16'hFFFF);
    @(negedge clk);
    lrc = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("midrst.pre_adcdat", adcdat, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst.adcdat", adcdat, 0);
    chk("midrst.ready",  bus.o_ready, 1);
    chk("midrst.busy",   busy, 0);
    chk("midrst.fcnt",   frame_cnt, 0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    lrc   = 1'b1;
    rst_n = 1'b1;
    frame_chk("postrst", 32, 0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 1, 3'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
